// File: rtl/shared_reg_scheduler_pkg.sv
// Shared types and helpers for shared_reg_scheduler: FSM states, requester
// indices in ring order, and ring-successor / one-hot decode helpers.
package shared_reg_scheduler_pkg;

  // Two-state handshake FSM: IDLE arbitrates, ACK lets the winner drop or renew.
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  // Requester indices, also the ring order W0 -> W1 -> RD -> W0.
  typedef enum logic [1:0] {
    REQ_W0 = 2'd0,
    REQ_W1 = 2'd1,
    REQ_RD = 2'd2
  } req_idx_e;

  localparam int NUM_REQ = 3;

  // Ring successor of a requester index.
  function automatic req_idx_e next_ptr(input req_idx_e idx);
    req_idx_e nxt;
    case (idx)
      REQ_W0:  nxt = REQ_W1;
      REQ_W1:  nxt = REQ_RD;
      default: nxt = REQ_W0;
    endcase
    return nxt;
  endfunction

  // Convert a one-hot winner vector (bit i = requester i) to its index.
  function automatic req_idx_e onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    req_idx_e idx;
    case (oh)
      3'b010:  idx = REQ_W1;
      3'b100:  idx = REQ_RD;
      default: idx = REQ_W0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/shared_reg_scheduler_rr_pick3.sv
// rr_pick3: combinational 3-way round-robin picker. Scans the request vector
// starting at ptr in ring order and returns the first requester as one-hot.
module rr_pick3
  import shared_reg_scheduler_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  req_idx_e p0;
  req_idx_e p1;
  req_idx_e p2;

  // Candidate order: ptr first, then its two ring successors. An out-of-range
  // ptr value is treated as W0 so the picker can never lock up.
  always_comb begin
    p0 = (ptr == 2'd3) ? REQ_W0 : req_idx_e'(ptr);
    p1 = next_ptr(p0);
    p2 = next_ptr(p1);
  end

  // First requesting candidate in ring order wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    grant = '0;
    if (req[p0]) begin
      grant[p0] = 1'b1;
    end else if (req[p1]) begin
      grant[p1] = 1'b1;
    end else if (req[p2]) begin
      grant[p2] = 1'b1;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/shared_reg_scheduler.sv
// shared_reg_scheduler: round-robin req/grant scheduler owning one WIDTH-bit
// register shared by two writers (W0, W1) and one reader (RD).
// Optional feature macro: SRS_GRANT_COUNT_EN adds wr_count_0/wr_count_1,
// per-writer grant counters wrapping modulo 2**CNT_WIDTH.
module shared_reg_scheduler
  import shared_reg_scheduler_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_req_0,
  input  logic [WIDTH-1:0] wr_data_0,
  output logic             gnt_0,
  input  logic             wr_req_1,
  input  logic [WIDTH-1:0] wr_data_1,
  output logic             gnt_1,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             last_writer
`ifdef SRS_GRANT_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] wr_count_0,
  output logic [CNT_WIDTH-1:0] wr_count_1
`endif
);

  // Reject nonsensical widths at elaboration.
  if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("shared_reg_scheduler: WIDTH and CNT_WIDTH must be >= 1");
  end

  state_e             state_q, state_d;
  req_idx_e           ptr_q, ptr_d;
  logic [WIDTH-1:0]   reg_q, reg_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic               gnt_0_q, gnt_0_d;
  logic               gnt_1_q, gnt_1_d;
  logic               rd_valid_q, rd_valid_d;
  logic               last_writer_q, last_writer_d;

  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_valid;
  logic               take;
  req_idx_e           win_idx;

  assign req_vec = {rd_req, wr_req_1, wr_req_0};

  rr_pick3 u_pick (
    .req   (req_vec),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // A grant is issued only from IDLE; ACK ignores all requests.
  assign take    = (state_q == IDLE) && pick_valid;
  assign win_idx = onehot_to_idx(pick_grant);

  // State register and all datapath/output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the shared storage is a single word, not an array, so it is reset
      // to zero along with every other flop.
      state_q       <= IDLE;
      ptr_q         <= REQ_W0;
      reg_q         <= '0;
      rd_data_q     <= '0;
      gnt_0_q       <= 1'b0;
      gnt_1_q       <= 1'b0;
      rd_valid_q    <= 1'b0;
      last_writer_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      reg_q         <= reg_d;
      rd_data_q     <= rd_data_d;
      gnt_0_q       <= gnt_0_d;
      gnt_1_q       <= gnt_1_d;
      rd_valid_q    <= rd_valid_d;
      last_writer_q <= last_writer_d;
    end
  end

  // Next-state logic: IDLE -> ACK on any grant, ACK always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic: apply the winner's action and advance the pointer.
  // Grant pulses default low, which clears them during ACK.
  always_comb begin
    ptr_d         = ptr_q;
    reg_d         = reg_q;
    rd_data_d     = rd_data_q;
    last_writer_d = last_writer_q;
    gnt_0_d       = 1'b0;
    gnt_1_d       = 1'b0;
    rd_valid_d    = 1'b0;
    if (take) begin
      ptr_d = next_ptr(win_idx);
      case (win_idx)
        REQ_W0: begin
          reg_d         = wr_data_0;
          gnt_0_d       = 1'b1;
          last_writer_d = 1'b0;
        end
        REQ_W1: begin
          reg_d         = wr_data_1;
          gnt_1_d       = 1'b1;
          last_writer_d = 1'b1;
        end
        default: begin
          // A read returns the value held before this edge; no write can be
          // granted in the same cycle.
          rd_data_d  = reg_q;
          rd_valid_d = 1'b1;
        end
      endcase
    end
  end

  assign gnt_0       = gnt_0_q;
  assign gnt_1       = gnt_1_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign last_writer = last_writer_q;

`ifdef SRS_GRANT_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_0_q, cnt_0_d;
  logic [CNT_WIDTH-1:0] cnt_1_q, cnt_1_d;

  // Grant counters advance on the same edge that raises the matching grant.
  always_comb begin
    cnt_0_d = cnt_0_q;
    cnt_1_d = cnt_1_q;
    if (gnt_0_d) cnt_0_d = cnt_0_q + CNT_WIDTH'(1);
    if (gnt_1_d) cnt_1_d = cnt_1_q + CNT_WIDTH'(1);
  end

  // Grant counter registers; wrap naturally at 2**CNT_WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_0_q <= '0;
      cnt_1_q <= '0;
    end else begin
      cnt_0_q <= cnt_0_d;
      cnt_1_q <= cnt_1_d;
    end
  end

  assign wr_count_0 = cnt_0_q;
  assign wr_count_1 = cnt_1_q;
`endif

endmodule

// File: tb/tb_shared_reg_scheduler.sv
// Testbench for shared_reg_scheduler: directed scenarios plus randomized
// req/grant traffic, checked by a scoreboard fed from a behavioural model.
module tb_shared_reg_scheduler;

  localparam int WIDTH = 16;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_req_0, wr_req_1, rd_req;
  logic [WIDTH-1:0] wr_data_0, wr_data_1;
  logic             gnt_0, gnt_1, rd_valid, last_writer;
  logic [WIDTH-1:0] rd_data;
`ifdef SRS_GRANT_COUNT_EN
  logic [CNT_W-1:0] wr_count_0, wr_count_1;
`endif

  always #5 clk = ~clk;

  shared_reg_scheduler #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_req_0    (wr_req_0),
    .wr_data_0   (wr_data_0),
    .gnt_0       (gnt_0),
    .wr_req_1    (wr_req_1),
    .wr_data_1   (wr_data_1),
    .gnt_1       (gnt_1),
    .rd_req      (rd_req),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .last_writer (last_writer)
`ifdef SRS_GRANT_COUNT_EN
    ,
    .wr_count_0  (wr_count_0),
    .wr_count_1  (wr_count_1)
`endif
  );

  // Expected output event: one-hot {rd_valid, gnt_1, gnt_0}, read data, cycle.
  typedef struct {
    logic [2:0]       vec;
    logic [WIDTH-1:0] data;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Behavioural model: register contents, reader view, ring position,
  // whether the previous edge granted (so this edge is the ACK gap).
  logic [WIDTH-1:0] m_reg, m_rd;
  logic             m_lw;
  int               m_ptr;
  bit               m_busy;
  int               m_won;
  int               m_cnt0, m_cnt1;

  logic [2:0] rr_seq [6] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_reg  = '0;
    m_rd   = '0;
    m_lw   = 1'b0;
    m_ptr  = 0;
    m_busy = 0;
    m_won  = -1;
    m_cnt0 = 0;
    m_cnt1 = 0;
    exp_q.delete();
  endtask

  // One clock edge of the reference behaviour, using the inputs seen at the edge.
  task automatic model_step();
    logic [2:0] r;
    int         w;
    exp_t       e;
    m_won = -1;
    if (reset) return;
    if (m_busy) begin
      m_busy = 0;
      return;
    end
    r = {rd_req, wr_req_1, wr_req_0};
    w = -1;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (w < 0 && r[i]) w = i;
    end
    if (w < 0) return;
    e.vec  = 3'b001 << w;
    e.data = m_reg;
    e.cyc  = cyc + 1;
    case (w)
      0:       begin m_reg = wr_data_0; m_lw = 1'b0; m_cnt0++; end
      1:       begin m_reg = wr_data_1; m_lw = 1'b1; m_cnt1++; end
      default: m_rd = m_reg;
    endcase
    exp_q.push_back(e);
    m_ptr  = (w + 1) % 3;
    m_busy = 1;
    m_won  = w;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) tick();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant/rd_valid.
  always @(negedge clk) begin : monitor
    logic [2:0] obs;
    exp_t       e;
    if (!reset) begin
      obs = {rd_valid, gnt_1, gnt_0};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missed_grant: got none, expected %b at cycle %0d", exp_q[0].vec, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (obs != 3'b000) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_grant: got %b, expected none (cycle %0d)", obs, cyc);
        end else begin
          e = exp_q.pop_front();
          check("grant_kind", 32'(obs), 32'(e.vec));
          check("grant_cycle", cyc, e.cyc);
          if (e.vec[2]) check("rd_data_on_valid", 32'(rd_data), 32'(e.data));
        end
      end
      check("rd_data_hold", 32'(rd_data), 32'(m_rd));
      check("last_writer", 32'(last_writer), 32'(m_lw));
    end
  end

  initial begin
    int  wt;
    bit  found;
    reset     = 1'b1;
    wr_req_0  = 1'b0;
    wr_req_1  = 1'b0;
    rd_req    = 1'b0;
    wr_data_0 = '0;
    wr_data_1 = '0;
    model_reset();
    repeat (3) tick();
    check("rst_gnt_0", 32'(gnt_0), 0);
    check("rst_gnt_1", 32'(gnt_1), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_last_writer", 32'(last_writer), 0);
    reset = 1'b0;

    // Single write then read back.
    wr_req_0 = 1'b1; wr_data_0 = 16'hA5A5;
    tick();
    wr_req_0 = 1'b0;
    check("t1_gnt_0", 32'(gnt_0), 1);
    tick();
    check("t1_gnt_0_pulse", 32'(gnt_0), 0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("t1_rd_valid", 32'(rd_valid), 1);
    check("t1_rd_data", 32'(rd_data), 32'h0000A5A5);
    check("t1_last_writer", 32'(last_writer), 0);
    tick();

    // All three requesters held high from reset: strict rotation.
    reset = 1'b1;
    model_reset();
    wr_req_0 = 1'b1; wr_data_0 = 16'h1111;
    wr_req_1 = 1'b1; wr_data_1 = 16'h2222;
    rd_req   = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("rr_seq", 32'({rd_valid, gnt_1, gnt_0}), 32'(rr_seq[c % 6]));
      if (c % 6 == 4) check("rr_rd_data", 32'(rd_data), 32'h00002222);
    end
    wr_req_0 = 1'b0; wr_req_1 = 1'b0; rd_req = 1'b0;
    repeat (2) tick();

    // W1 hogging: a single W0 request must still be served within 6 cycles.
    assert_reset();
    wr_req_1 = 1'b1; wr_data_1 = 16'h7777;
    reset = 1'b0;
    repeat (3) tick();
    wr_req_0 = 1'b1; wr_data_0 = 16'h3C3C;
    wt = 0;
    found = 0;
    while (!found && wt < 10) begin
      tick();
      wt++;
      if (gnt_0) found = 1;
    end
    wr_req_0 = 1'b0;
    check("starve_found", 32'(found), 1);
    check("starve_wait_le_6", 32'(wt <= 6), 1);
    wr_req_1 = 1'b0;
    repeat (2) tick();

    // Reset during ACK after gnt_1, then read from a never-written register.
    assert_reset();
    reset = 1'b0;
    wr_req_1 = 1'b1; wr_data_1 = 16'hBEEF;
    tick();
    wr_req_1 = 1'b0;
    check("ack_gnt_1_high", 32'(gnt_1), 1);
    reset = 1'b1;
    model_reset();
    #1;
    check("ack_rst_gnt_1", 32'(gnt_1), 0);
    check("ack_rst_last_writer", 32'(last_writer), 0);
    repeat (2) tick();
    reset = 1'b0;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("post_rst_rd_valid", 32'(rd_valid), 1);
    check("post_rst_rd_data", 32'(rd_data), 0);
    tick();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("reread_rd_data", 32'(rd_data), 0);
    tick();

`ifdef SRS_GRANT_COUNT_EN
    // Five W0 grants with a 2-bit counter wrap to 1.
    assert_reset();
    reset = 1'b0;
    for (int g = 0; g < 5; g++) begin
      wr_req_0 = 1'b1; wr_data_0 = 16'($urandom);
      tick();
      wr_req_0 = 1'b0;
      tick();
    end
    check("cnt_wrap_0", 32'(wr_count_0), 1);
    check("cnt_wrap_1", 32'(wr_count_1), 0);
`endif

    // Randomized traffic obeying the hold-until-grant protocol.
    assert_reset();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (wr_req_0) begin
        if (m_won == 0) begin
          if ($urandom_range(1) == 0) wr_req_0 = 1'b0;
          else wr_data_0 = 16'($urandom);
        end else if ($urandom_range(15) == 0) wr_req_0 = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        wr_req_0 = 1'b1; wr_data_0 = 16'($urandom);
      end
      if (wr_req_1) begin
        if (m_won == 1) begin
          if ($urandom_range(1) == 0) wr_req_1 = 1'b0;
          else wr_data_1 = 16'($urandom);
        end else if ($urandom_range(15) == 0) wr_req_1 = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        wr_req_1 = 1'b1; wr_data_1 = 16'($urandom);
      end
      if (rd_req) begin
        if (m_won == 2) begin
          if ($urandom_range(1) == 0) rd_req = 1'b0;
        end else if ($urandom_range(15) == 0) rd_req = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        rd_req = 1'b1;
      end
    end
    wr_req_0 = 1'b0; wr_req_1 = 1'b0; rd_req = 1'b0;
    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 0);
`ifdef SRS_GRANT_COUNT_EN
    check("rand_cnt_0", 32'(wr_count_0), 32'(m_cnt0 % (1 << CNT_W)));
    check("rand_cnt_1", 32'(wr_count_1), 32'(m_cnt1 % (1 << CNT_W)));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
